// File: rtl/gtxe2_chnl_rst_seq_pkg.sv
// Shared definitions for the GTXE2 channel reset sequencer: state codes,
// default cycle counts and a small sizing helper.
package gtxe2_chnl_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK   = 3'd0,
    ST_PMA_RST     = 3'd1,
    ST_WAIT_USRRDY = 3'd2,
    ST_PCS_RST     = 3'd3,
    ST_DONE        = 3'd4
  } state_e;

  localparam int unsigned DEF_LOCK_FILTER    = 32'd2;
  localparam int unsigned DEF_PMA_RST_CYCLES = 32'd8;
  localparam int unsigned DEF_PCS_RST_CYCLES = 32'd4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gtxe2_chnl_sync2.sv
// Two-flop synchronizer with asynchronous reset to 0.
module gtxe2_chnl_sync2
  import gtxe2_chnl_rst_seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // next values of the synchronizer chain
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // synchronizer flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/gtxe2_chnl_rst_seq.sv
// Channel reset sequencer: filtered CPLL lock -> PMA reset -> wait for user
// ready -> PCS reset -> reset done. All outputs are flops, reset asynchronously.
module gtxe2_chnl_rst_seq
  import gtxe2_chnl_rst_seq_pkg::*;
#(
  parameter int unsigned LOCK_FILTER    = DEF_LOCK_FILTER,
  parameter int unsigned PMA_RST_CYCLES = DEF_PMA_RST_CYCLES,
  parameter int unsigned PCS_RST_CYCLES = DEF_PCS_RST_CYCLES
) (
  input  logic       ref_clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       userrdy,
  input  logic       pcs_reset_req,
  output logic       pma_rst,
  output logic       pcs_rst,
  output logic       reset_done,
  output logic [2:0] state
);

  localparam int unsigned CNT_W  = $clog2(max_u(PMA_RST_CYCLES, PCS_RST_CYCLES) + 32'd1);
  localparam int unsigned LOCK_W = $clog2(LOCK_FILTER + 32'd1);

  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  PMA_LOAD  = CNT_W'(PMA_RST_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0]  PCS_LOAD  = CNT_W'(PCS_RST_CYCLES - 32'd1);
  localparam logic [LOCK_W-1:0] LOCK_ZERO = LOCK_W'(0);
  localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_FILTER - 32'd1);

  logic              userrdy_s;
  logic              req_rise_s;
  logic              req_d1_q, req_d1_d;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              pma_rst_q, pma_rst_d;
  logic              pcs_rst_q, pcs_rst_d;
  logic              reset_done_q, reset_done_d;

  gtxe2_chnl_sync2 u_userrdy_sync (
    .clk   (ref_clk),
    .reset (reset),
    .d     (userrdy),
    .q     (userrdy_s)
  );

  assign req_rise_s = pcs_reset_req & ~req_d1_q;

  // next-state, counters and output decode of the next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lock_cnt_d = lock_cnt_q;
    req_d1_d   = pcs_reset_req;

    // losing lock outranks every per-state rule
    if ((state_q != ST_WAIT_LOCK) && !pll_locked) begin
      state_d    = ST_WAIT_LOCK;
      lock_cnt_d = LOCK_ZERO;
      cnt_d      = CNT_ZERO;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (pll_locked) begin
            if (lock_cnt_q == LOCK_LAST) begin
              state_d    = ST_PMA_RST;
              cnt_d      = PMA_LOAD;
              lock_cnt_d = LOCK_ZERO;
            end else begin
              lock_cnt_d = lock_cnt_q + LOCK_ONE;
            end
          end else begin
            lock_cnt_d = LOCK_ZERO;
          end
        end
        ST_PMA_RST: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_WAIT_USRRDY;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_WAIT_USRRDY: begin
          if (userrdy_s) begin
            state_d = ST_PCS_RST;
            cnt_d   = PCS_LOAD;
          end else begin
            state_d = ST_WAIT_USRRDY;
          end
        end
        ST_PCS_RST: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_DONE: begin
          if (!userrdy_s) begin
            state_d = ST_WAIT_USRRDY;
          end else if (req_rise_s) begin
            state_d = ST_PCS_RST;
            cnt_d   = PCS_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d    = ST_WAIT_LOCK;
          lock_cnt_d = LOCK_ZERO;
          cnt_d      = CNT_ZERO;
        end
      endcase
    end

    pma_rst_d    = (state_d == ST_WAIT_LOCK) || (state_d == ST_PMA_RST);
    pcs_rst_d    = (state_d != ST_DONE);
    reset_done_d = (state_d == ST_DONE);
  end

  // state, counters, request edge register and registered outputs
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_WAIT_LOCK;
      cnt_q        <= CNT_ZERO;
      lock_cnt_q   <= LOCK_ZERO;
      req_d1_q     <= 1'b0;
      pma_rst_q    <= 1'b1;
      pcs_rst_q    <= 1'b1;
      reset_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      req_d1_q     <= req_d1_d;
      pma_rst_q    <= pma_rst_d;
      pcs_rst_q    <= pcs_rst_d;
      reset_done_q <= reset_done_d;
    end
  end

  assign pma_rst    = pma_rst_q;
  assign pcs_rst    = pcs_rst_q;
  assign reset_done = reset_done_q;
  assign state      = state_q;

endmodule

// File: tb/tb_gtxe2_chnl_rst_seq.sv
// Self-checking bench for gtxe2_chnl_rst_seq: a nominal-sequence vector table,
// hand-written corner sequences and random stimulus against a timeline model.
module tb_gtxe2_chnl_rst_seq;

  localparam int LF  = 2;
  localparam int PMA = 8;
  localparam int PCS = 4;

  logic       ref_clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       userrdy;
  logic       pcs_reset_req;
  logic       pma_rst;
  logic       pcs_rst;
  logic       reset_done;
  logic [2:0] state;

  int nchk = 0;
  int nerr = 0;

  gtxe2_chnl_rst_seq #(
    .LOCK_FILTER    (LF),
    .PMA_RST_CYCLES (PMA),
    .PCS_RST_CYCLES (PCS)
  ) dut (
    .ref_clk       (ref_clk),
    .reset         (reset),
    .pll_locked    (pll_locked),
    .userrdy       (userrdy),
    .pcs_reset_req (pcs_reset_req),
    .pma_rst       (pma_rst),
    .pcs_rst       (pcs_rst),
    .reset_done    (reset_done),
    .state         (state)
  );

  always #5 ref_clk = ~ref_clk;

  // Reference model: phase number, edges spent in the phase, run length of
  // consecutive lock samples, and a history of sampled userrdy values.
  int m_st;
  int m_age;
  int m_run;
  bit m_prev_req;
  bit ur_hist[$];

  typedef struct {
    bit         lk;
    bit         ur;
    bit         rq;
    logic [2:0] st;
    bit         pma;
    bit         pcs;
    bit         done;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0;
    m_age = 0;
    m_run = 0;
    m_prev_req = 1'b0;
    ur_hist.delete();
  endtask

  task automatic model_edge(input bit lk, input bit ur, input bit rq);
    bit urs;
    bit rise;
    // userrdy seen by the sequencer is the value sampled two edges earlier
    urs = (ur_hist.size() >= 2) ? ur_hist[ur_hist.size() - 2] : 1'b0;
    ur_hist.push_back(ur);
    if (ur_hist.size() > 4) void'(ur_hist.pop_front());
    rise = rq && !m_prev_req;
    m_prev_req = rq;
    if (m_st != 0 && !lk) begin
      m_st = 0; m_run = 0; m_age = 0;
    end else if (m_st == 0) begin
      m_run = lk ? m_run + 1 : 0;
      if (m_run >= LF) begin m_st = 1; m_run = 0; m_age = 0; end
    end else if (m_st == 1) begin
      m_age++;
      if (m_age >= PMA) begin m_st = 2; m_age = 0; end
    end else if (m_st == 2) begin
      if (urs) begin m_st = 3; m_age = 0; end
    end else if (m_st == 3) begin
      m_age++;
      if (m_age >= PCS) begin m_st = 4; m_age = 0; end
    end else begin
      if (!urs) begin m_st = 2; m_age = 0; end
      else if (rise) begin m_st = 3; m_age = 0; end
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".state"}, state, m_st);
    check({tag, ".pma_rst"}, pma_rst, (m_st <= 1) ? 1 : 0);
    check({tag, ".pcs_rst"}, pcs_rst, (m_st != 4) ? 1 : 0);
    check({tag, ".reset_done"}, reset_done, (m_st == 4) ? 1 : 0);
  endtask

  task automatic step(input bit lk, input bit ur, input bit rq, input string tag);
    pll_locked = lk;
    userrdy = ur;
    pcs_reset_req = rq;
    @(posedge ref_clk);
    model_edge(lk, ur, rq);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset(input bit ur);
    reset = 1'b1;
    pll_locked = 1'b0;
    userrdy = ur;
    pcs_reset_req = 1'b0;
    model_reset();
    #1;
    check("rst.state", state, 0);
    check("rst.pma_rst", pma_rst, 1);
    check("rst.pcs_rst", pcs_rst, 1);
    check("rst.reset_done", reset_done, 0);
    @(posedge ref_clk);
    @(posedge ref_clk);
    #3;
    reset = 1'b0;
  endtask

  task automatic wait_until(input int target, input bit lk, input bit ur, input int budget);
    int n;
    n = 0;
    while (m_st != target && n < budget) begin
      step(lk, ur, 1'b0, "wait");
      n++;
    end
    check("reach_state", state, target);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 16; i++) begin
      pll_locked = tbl[i].lk;
      userrdy = tbl[i].ur;
      pcs_reset_req = tbl[i].rq;
      @(posedge ref_clk);
      model_edge(tbl[i].lk, tbl[i].ur, tbl[i].rq);
      #1;
      check({tag, ".state"}, state, tbl[i].st);
      check({tag, ".pma_rst"}, pma_rst, tbl[i].pma);
      check({tag, ".pcs_rst"}, pcs_rst, tbl[i].pcs);
      check({tag, ".reset_done"}, reset_done, tbl[i].done);
    end
  endtask

  initial begin
    // Nominal sequence, entry i is the value after edge E0+i.
    for (int i = 0; i < 16; i++) begin
      tbl[i].lk = 1'b1;
      tbl[i].ur = 1'b1;
      tbl[i].rq = (i == 5 || i == 12) ? 1'b1 : 1'b0;
      tbl[i].st = (i == 0) ? 3'd0 : (i <= 8) ? 3'd1 : (i == 9) ? 3'd2 : (i <= 13) ? 3'd3 : 3'd4;
      tbl[i].pma = (i <= 8);
      tbl[i].pcs = (i <= 13);
      tbl[i].done = (i >= 14);
    end

    do_reset(1'b1);
    run_table("nominal");

    // single-cycle lock pulse is filtered
    do_reset(1'b1);
    step(1'b1, 1'b1, 1'b0, "pulse_hi");
    check("pulse.state_hi", state, 0);
    step(1'b0, 1'b1, 1'b0, "pulse_lo");
    check("pulse.state_lo", state, 0);
    step(1'b1, 1'b1, 1'b0, "steady1");
    check("pulse.steady1", state, 0);
    step(1'b1, 1'b1, 1'b0, "steady2");
    check("pulse.steady2", state, 1);

    // userrdy low through PMA_RST holds in WAIT_USRRDY
    do_reset(1'b0);
    wait_until(2, 1'b1, 1'b0, 30);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, "hold");
      check("hold.state", state, 2);
      check("hold.pma_rst", pma_rst, 0);
      check("hold.pcs_rst", pcs_rst, 1);
    end
    step(1'b1, 1'b1, 1'b0, "ur_e0");
    check("ur.e0", state, 2);
    step(1'b1, 1'b1, 1'b0, "ur_e1");
    check("ur.e1", state, 2);
    step(1'b1, 1'b1, 1'b0, "ur_e2");
    check("ur.e2", state, 3);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, "ur_pcs");
      check("ur.pcs", state, (i < 3) ? 3 : 4);
    end

    // PCS-only request from DONE, held level, request during PCS_RST
    step(1'b1, 1'b1, 1'b1, "req_rise");
    check("req.state", state, 3);
    check("req.pma_rst", pma_rst, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, "req_held");
      check("req.pcs_rst", pcs_rst, (i < 3) ? 1 : 0);
      check("req.pma_low", pma_rst, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, "req_level");
      check("req.no_retrigger", state, 4);
    end
    step(1'b1, 1'b1, 1'b0, "req_low");
    step(1'b1, 1'b1, 1'b1, "req_rise2");
    check("req2.state", state, 3);
    step(1'b1, 1'b1, 1'b0, "in_pcs");
    step(1'b1, 1'b1, 1'b1, "ign_rise");
    check("ign.state", state, 3);
    step(1'b1, 1'b1, 1'b0, "ign_a3");
    check("ign.a3", state, 3);
    step(1'b1, 1'b1, 1'b0, "ign_a4");
    check("ign.done", state, 4);
    step(1'b1, 1'b1, 1'b0, "not_queued");
    check("ign.not_queued", state, 4);

    // lock loss in DONE with same-edge userrdy drop and request
    step(1'b0, 1'b0, 1'b1, "drop_done");
    check("drop_done.state", state, 0);
    check("drop_done.pma_rst", pma_rst, 1);
    check("drop_done.reset_done", reset_done, 0);
    wait_until(3, 1'b1, 1'b1, 40);
    step(1'b0, 1'b1, 1'b1, "drop_pcs");
    check("drop_pcs.state", state, 0);
    check("drop_pcs.pma_rst", pma_rst, 1);

    // async reset between edges in PMA_RST, then full sequence again
    do_reset(1'b1);
    step(1'b1, 1'b1, 1'b0, "pre_pma0");
    step(1'b1, 1'b1, 1'b0, "pre_pma1");
    step(1'b1, 1'b1, 1'b0, "pre_pma2");
    check("mid.in_pma", state, 1);
    #3;
    do_reset(1'b1);
    run_table("after_reset");

    // random stimulus against the model
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end else begin
        step($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 92,
             $urandom_range(0, 99) < 25, "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
